// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types and defaults for the pipeline hazard/redirect controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pipe_st_e;

    localparam int FLUSH_CYCLES_DEF = 1;
    localparam int FLUSH_W          = 4;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module : pipe_ctrl_if
// Brief  : EX/fetch request and PC/pipe-register control bundle of pipe_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;

    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_req;
    logic        hold_bus_req;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        pc_stall;
    logic        if_id_flush;
    logic        id_ex_flush;

    // Requester side (EX stage / fetch unit) that also observes the controls
    modport master (
        output jump_en_i, jump_addr_i, hold_ex_req, hold_bus_req,
        input  jump_en_o, jump_addr_o, pc_stall, if_id_flush, id_ex_flush
    );

    modport slave (
        input  jump_en_i, jump_addr_i, hold_ex_req, hold_bus_req,
        output jump_en_o, jump_addr_o, pc_stall, if_id_flush, id_ex_flush
    );

endinterface

`default_nettype wire

// File: rtl/ctrl_sat_cnt.sv
// ============================================================================
// Module : ctrl_sat_cnt
// Brief  : 32-bit up-counter that sticks at all-ones; optional parallel load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_sat_cnt (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst_n,
    input  wire logic        inc_i,
    input  wire logic        load_i,
    input  wire logic [31:0] load_val_i,
    output logic      [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module : pipe_ctrl
// Brief  : Hazard/redirect controller: arbitrates EX jumps, EX and bus stalls,
//          and replays a jump that arrived during a bus stall.
//          Optional perf counters enabled by `define PIPE_CTRL_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst_n,
    pipe_ctrl_if.slave       bus,
    output logic      [31:0] stall_cnt,
    output logic      [31:0] flush_cnt
);

    pipe_st_e            st_q, st_d;
    logic [FLUSH_W-1:0]  flush_left_q, flush_left_d;
    logic                pend_vld_q, pend_vld_d;
    logic [31:0]         pend_addr_q, pend_addr_d;

    logic                jump_en;
    logic [31:0]         jump_addr;
    logic                pc_stall;
    logic                if_id_flush;
    logic                id_ex_flush;

    always_comb begin
        st_d         = st_q;
        flush_left_d = flush_left_q;
        pend_vld_d   = pend_vld_q;
        pend_addr_d  = pend_addr_q;
        jump_en      = 1'b0;
        jump_addr    = 32'd0;
        pc_stall     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;

        // Outputs are forced low while reset is asserted, even with requests pending
        if (sys_rst_n) begin
            if (bus.hold_bus_req) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                if (bus.jump_en_i) begin
                    pend_vld_d  = 1'b1;
                    pend_addr_d = bus.jump_addr_i;
                end
            end else if (bus.jump_en_i || pend_vld_q) begin
                jump_en     = 1'b1;
                jump_addr   = bus.jump_en_i ? bus.jump_addr_i : pend_addr_q;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                pend_vld_d  = 1'b0;
                if (FLUSH_CYCLES > 1) begin
                    st_d         = ST_FLUSH;
                    flush_left_d = FLUSH_W'(FLUSH_CYCLES - 1);
                end else begin
                    st_d         = ST_RUN;
                    flush_left_d = '0;
                end
            end else begin
                if (bus.hold_ex_req) begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                // The flush window keeps draining underneath an EX stall
                if (st_q == ST_FLUSH) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    flush_left_d = flush_left_q - 1'b1;
                    if (flush_left_q == FLUSH_W'(1)) begin
                        st_d = ST_RUN;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q         <= ST_RUN;
            flush_left_q <= '0;
            pend_vld_q   <= 1'b0;
            pend_addr_q  <= 32'd0;
        end else begin
            st_q         <= st_d;
            flush_left_q <= flush_left_d;
            pend_vld_q   <= pend_vld_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign bus.jump_en_o   = jump_en;
    assign bus.jump_addr_o = jump_addr;
    assign bus.pc_stall    = pc_stall;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;

`ifdef PIPE_CTRL_PERF_EN
    ctrl_sat_cnt u_stall_cnt (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .inc_i      (pc_stall),
        .load_i     (1'b0),
        .load_val_i (32'd0),
        .cnt_o      (stall_cnt)
    );

    ctrl_sat_cnt u_flush_cnt (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .inc_i      (jump_en),
        .load_i     (1'b0),
        .load_val_i (32'd0),
        .cnt_o      (flush_cnt)
    );
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module : tb_pipe_ctrl
// Brief  : Directed self-checking bench for pipe_ctrl (FLUSH_CYCLES 1 and 3)
//          and the saturating counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
    logic        sc_inc, sc_load;
    logic [31:0] sc_val, sc_cnt;

    int errors = 0;
    int checks = 0;

    pipe_ctrl_if bus1 ();
    pipe_ctrl_if bus3 ();

    pipe_ctrl #(.FLUSH_CYCLES(1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus1.slave),
        .stall_cnt (stall_cnt1),
        .flush_cnt (flush_cnt1)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus3.slave),
        .stall_cnt (stall_cnt3),
        .flush_cnt (flush_cnt3)
    );

    ctrl_sat_cnt u_sat (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .inc_i      (sc_inc),
        .load_i     (sc_load),
        .load_val_i (sc_val),
        .cnt_o      (sc_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive1(input logic je, input logic [31:0] ja, input logic hex, input logic hbus);
        bus1.jump_en_i    = je;
        bus1.jump_addr_i  = ja;
        bus1.hold_ex_req  = hex;
        bus1.hold_bus_req = hbus;
    endtask

    task automatic drive3(input logic je, input logic [31:0] ja);
        bus3.jump_en_i    = je;
        bus3.jump_addr_i  = ja;
        bus3.hold_ex_req  = 1'b0;
        bus3.hold_bus_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] v;
        sys_rst_n = 1'b0;
        drive1(1'b0, 32'd0, 1'b0, 1'b0);
        drive3(1'b0, 32'd0);
        sc_inc = 1'b0; sc_load = 1'b0; sc_val = 32'd0;
        tick(); tick();
        #1;
        v = {bus1.jump_en_o, bus1.pc_stall, bus1.if_id_flush, bus1.id_ex_flush};
        checks++;
        if (v !== 4'b0000 || bus1.jump_addr_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b addr=%h, want ctl=0000 addr=0", v, bus1.jump_addr_o);
        end
        checks++;
        if (stall_cnt1 !== 32'd0 || flush_cnt1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d, want 0 0", stall_cnt1, flush_cnt1);
        end
        tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic test_jump_fc1();
        logic [3:0] v;
        tick();
        drive1(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        #1;
        v = {bus1.jump_en_o, bus1.pc_stall, bus1.if_id_flush, bus1.id_ex_flush};
        checks++;
        if (v !== 4'b1011 || bus1.jump_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL jump_fc1_c0: got ctl=%b addr=%h, want ctl=1011 addr=00000100", v, bus1.jump_addr_o);
        end
        tick();
        drive1(1'b0, 32'h0000_0100, 1'b0, 1'b0);
        #1;
        v = {bus1.jump_en_o, bus1.pc_stall, bus1.if_id_flush, bus1.id_ex_flush};
        checks++;
        if (v !== 4'b0000 || bus1.jump_addr_o !== 32'd0) begin
            errors++;
            $display("FAIL jump_fc1_c1: got ctl=%b addr=%h, want ctl=0000 addr=0", v, bus1.jump_addr_o);
        end
    endtask

    task automatic test_flush3();
        // per cycle: jump_en_i, jump_addr_i, expected {jump_en_o,pc_stall,if_id,id_ex}, expected addr
        logic        je  [10] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
        logic [31:0] ja  [10] = '{32'h10, 0, 0, 0, 32'h20, 0, 32'h30, 0, 0, 0};
        logic [3:0]  ev  [10] = '{4'b1011, 4'b0011, 4'b0011, 4'b0000, 4'b1011,
                                  4'b0011, 4'b1011, 4'b0011, 4'b0011, 4'b0000};
        logic [3:0]  v;
        for (int i = 0; i < 10; i++) begin
            tick();
            drive3(je[i], ja[i]);
            #1;
            v = {bus3.jump_en_o, bus3.pc_stall, bus3.if_id_flush, bus3.id_ex_flush};
            checks++;
            if (v !== ev[i] || bus3.jump_addr_o !== (je[i] ? ja[i] : 32'd0)) begin
                errors++;
                $display("FAIL flush3_c%0d: got ctl=%b addr=%h, want ctl=%b addr=%h",
                         i, v, bus3.jump_addr_o, ev[i], je[i] ? ja[i] : 32'd0);
            end
        end
    endtask

    task automatic test_async_reset_pend();
        logic [3:0] v;
        tick();
        drive1(1'b1, 32'h0000_0500, 1'b0, 1'b1);
        tick();
        drive1(1'b0, 32'd0, 1'b0, 1'b1);
        #1;
        sys_rst_n = 1'b0;
        #1;
        v = {bus1.jump_en_o, bus1.pc_stall, bus1.if_id_flush, bus1.id_ex_flush};
        checks++;
        if (v !== 4'b0000 || bus1.jump_addr_o !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_immediate: got ctl=%b addr=%h, want ctl=0000 addr=0", v, bus1.jump_addr_o);
        end
        drive1(1'b0, 32'd0, 1'b0, 1'b0);
        tick(); tick();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            v = {bus1.jump_en_o, bus1.pc_stall, bus1.if_id_flush, bus1.id_ex_flush};
            checks++;
            if (v !== 4'b0000) begin
                errors++;
                $display("FAIL async_reset_no_replay_c%0d: got ctl=%b, want ctl=0000", i, v);
            end
            tick();
        end
    endtask

    task automatic test_bus_stall();
        logic        je  [6] = '{0, 1, 1, 0, 0, 0};
        logic [31:0] ja  [6] = '{0, 32'h200, 32'h300, 0, 0, 0};
        logic        hb  [6] = '{1, 1, 1, 1, 0, 0};
        logic [3:0]  ev  [6] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b1011, 4'b0000};
        logic [31:0] ea  [6] = '{0, 0, 0, 0, 32'h300, 0};
        logic [3:0]  v;
        for (int i = 0; i < 6; i++) begin
            tick();
            drive1(je[i], ja[i], 1'b0, hb[i]);
            #1;
            v = {bus1.jump_en_o, bus1.pc_stall, bus1.if_id_flush, bus1.id_ex_flush};
            checks++;
            if (v !== ev[i] || bus1.jump_addr_o !== ea[i]) begin
                errors++;
                $display("FAIL bus_stall_c%0d: got ctl=%b addr=%h, want ctl=%b addr=%h",
                         i, v, bus1.jump_addr_o, ev[i], ea[i]);
            end
        end
    endtask

    task automatic test_ex_stall();
        logic [3:0]  v;
        logic [3:0]  ev;
        logic [31:0] ea;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < 5) drive1(1'b0, 32'd0, 1'b1, 1'b0);
            else if (i == 5) drive1(1'b1, 32'h44, 1'b0, 1'b0);
            else drive1(1'b0, 32'd0, 1'b0, 1'b0);
            ev = (i < 5) ? 4'b0111 : (i == 5) ? 4'b1011 : 4'b0000;
            ea = (i == 5) ? 32'h44 : 32'd0;
            #1;
            v = {bus1.jump_en_o, bus1.pc_stall, bus1.if_id_flush, bus1.id_ex_flush};
            checks++;
            if (v !== ev || bus1.jump_addr_o !== ea) begin
                errors++;
                $display("FAIL ex_stall_c%0d: got ctl=%b addr=%h, want ctl=%b addr=%h",
                         i, v, bus1.jump_addr_o, ev, ea);
            end
        end
    endtask

    task automatic test_perf_counters();
        logic [31:0] es, ef;
`ifdef PIPE_CTRL_PERF_EN
        es = 32'd9;
        ef = 32'd2;
`else
        es = 32'd0;
        ef = 32'd0;
`endif
        tick();
        checks++;
        if (stall_cnt1 !== es) begin
            errors++;
            $display("FAIL perf_stall_cnt: got %0d, want %0d", stall_cnt1, es);
        end
        checks++;
        if (flush_cnt1 !== ef) begin
            errors++;
            $display("FAIL perf_flush_cnt: got %0d, want %0d", flush_cnt1, ef);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] ec [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tick();
        sc_load = 1'b1; sc_val = 32'hFFFF_FFFD; sc_inc = 1'b0;
        tick();
        sc_load = 1'b0;
        #1;
        checks++;
        if (sc_cnt !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL sat_load: got %h, want fffffffd", sc_cnt);
        end
        sc_inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sc_cnt !== ec[i]) begin
                errors++;
                $display("FAIL sat_inc_%0d: got %h, want %h", i, sc_cnt, ec[i]);
            end
        end
        sc_inc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_jump_fc1();
        test_flush3();
        test_async_reset_pend();
        test_bus_stall();
        test_ex_stall();
        test_perf_counters();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
